// File: rtl/duck_flight_ctrl.sv
// Duck trajectory sequencer: loads/waits an external down_counter, then moves and bounces the duck once per expiry.
// Build option DUCK_FALL_ANIM_EN: a hit animates the fall to the grass line instead of ending after one more wait.
module duck_flight_ctrl #(
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int DLY_W     = 10,
  parameter int X_MAX     = 639,
  parameter int Y_FLOOR   = 399,
  parameter int ESC_STEPS = 64,
  parameter int ESC_SPEED = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [X_W-1:0]    start_x,
  input  logic [Y_W-1:0]    start_y,
  input  logic signed [3:0] vx,
  input  logic signed [3:0] vy,
  input  logic [DLY_W-1:0]  step_delay,
  input  logic              hit,
  output logic              timer_ld,
  output logic              timer_en,
  output logic [DLY_W-1:0]  timer_data,
  input  logic              timer_done,
  output logic [X_W-1:0]    duck_x,
  output logic [Y_W-1:0]    duck_y,
  output logic              dir_left,
  output logic              active,
  output logic              falling,
  output logic              escaped,
  output logic              round_done
);
  localparam int CNT_W = $clog2(ESC_STEPS + 1);
  localparam logic [CNT_W-1:0]  ESC_CNT = CNT_W'(ESC_STEPS);
  localparam logic signed [X_W:0] XMAX_S = (X_W+1)'(X_MAX);
  localparam logic signed [Y_W:0] YFLR_S = (Y_W+1)'(Y_FLOOR);
  localparam logic [Y_W-1:0]    ESC_DY = Y_W'(ESC_SPEED);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_STEP} state_t;
  typedef enum logic [1:0] {M_FLY, M_ESC, M_FALL} mode_t;

  state_t state, state_n;
  mode_t  mode, mode_n;
  // Velocity kept one bit wider so that negating -8 on a bounce yields +8.
  logic signed [4:0]  vx_q, vy_q, vx_n, vy_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [X_W-1:0]     x_n;
  logic [Y_W-1:0]     y_n;
  logic [DLY_W-1:0]   dly_n;
  logic               ld_n, en_n, act_n, fall_n, esc_n, done_n;
  logic               hit_ok, fin, fin_esc;
  logic signed [X_W:0] xs;
  logic signed [Y_W:0] ys;

  assign xs = $signed({1'b0, duck_x}) + $signed({{(X_W-4){vx_q[4]}}, vx_q});
  assign ys = $signed({1'b0, duck_y}) + $signed({{(Y_W-4){vy_q[4]}}, vy_q});
  assign dir_left = vx_q[4];

`ifdef DUCK_FALL_ANIM_EN
  localparam logic [Y_W:0] FALL_DY = (Y_W+1)'(8);
  localparam logic [Y_W:0] YFLR_U  = (Y_W+1)'(Y_FLOOR);
  logic [Y_W:0] yf;
  assign yf = {1'b0, duck_y} + FALL_DY;
`endif

  always_comb begin
    state_n = state;
    mode_n  = mode;
    vx_n    = vx_q;
    vy_n    = vy_q;
    cnt_n   = cnt;
    x_n     = duck_x;
    y_n     = duck_y;
    dly_n   = timer_data;
    act_n   = active;
    fall_n  = falling;
    esc_n   = 1'b0;
    done_n  = 1'b0;
    fin     = 1'b0;
    fin_esc = 1'b0;
    hit_ok  = hit && (state != S_IDLE) && (mode != M_FALL);
    case (state)
      S_IDLE: if (start) begin
        x_n     = start_x;
        y_n     = start_y;
        vx_n    = {vx[3], vx};
        vy_n    = {vy[3], vy};
        dly_n   = step_delay;
        mode_n  = M_FLY;
        cnt_n   = '0;
        act_n   = 1'b1;
        fall_n  = 1'b0;
        state_n = S_LOAD;
      end
      S_LOAD: state_n = S_WAIT;
      S_WAIT: if (timer_done) state_n = S_STEP;
      S_STEP: begin
        state_n = S_LOAD;
        case (mode)
          M_FLY: begin
            if (xs < 0) begin
              x_n  = '0;
              vx_n = -vx_q;
            end else if (xs > XMAX_S) begin
              x_n  = XMAX_S[X_W-1:0];
              vx_n = -vx_q;
            end else begin
              x_n = xs[X_W-1:0];
            end
            if (ys < 0) begin
              y_n  = '0;
              vy_n = -vy_q;
            end else if (ys > YFLR_S) begin
              y_n  = YFLR_S[Y_W-1:0];
              vy_n = -vy_q;
            end else begin
              y_n = ys[Y_W-1:0];
            end
            cnt_n = cnt + CNT_W'(1);
            if (cnt_n == ESC_CNT) mode_n = M_ESC;
          end
          M_ESC: begin
            if (duck_y <= ESC_DY) begin
              y_n     = '0;
              fin     = 1'b1;
              fin_esc = 1'b1;
            end else begin
              y_n = duck_y - ESC_DY;
            end
          end
          default: begin
`ifdef DUCK_FALL_ANIM_EN
            if (yf >= YFLR_U) begin
              y_n = YFLR_U[Y_W-1:0];
              fin = 1'b1;
            end else begin
              y_n = yf[Y_W-1:0];
            end
`else
            fin = 1'b1;
`endif
          end
        endcase
      end
      default: state_n = S_IDLE;
    endcase
    // A hit sampled together with timer_done lands in mode before STEP, so that step uses fall rules.
    if (hit_ok) begin
      mode_n = M_FALL;
      fall_n = 1'b1;
    end
    if (fin) begin
      state_n = S_IDLE;
      act_n   = 1'b0;
      fall_n  = 1'b0;
      done_n  = 1'b1;
      esc_n   = fin_esc;
    end
    ld_n = (state_n == S_LOAD);
    en_n = (state_n == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      mode       <= M_FLY;
      vx_q       <= '0;
      vy_q       <= '0;
      cnt        <= '0;
      duck_x     <= '0;
      duck_y     <= '0;
      timer_data <= '0;
      timer_ld   <= 1'b0;
      timer_en   <= 1'b0;
      active     <= 1'b0;
      falling    <= 1'b0;
      escaped    <= 1'b0;
      round_done <= 1'b0;
    end else begin
      state      <= state_n;
      mode       <= mode_n;
      vx_q       <= vx_n;
      vy_q       <= vy_n;
      cnt        <= cnt_n;
      duck_x     <= x_n;
      duck_y     <= y_n;
      timer_data <= dly_n;
      timer_ld   <= ld_n;
      timer_en   <= en_n;
      active     <= act_n;
      falling    <= fall_n;
      escaped    <= esc_n;
      round_done <= done_n;
    end
  end
endmodule

// File: doc/duck_flight_ctrl.md
# duck_flight_ctrl

Sequencer that drives one duck's on-screen trajectory by time-slicing an external `down_counter`. It loads the counter with the per-step delay, holds its enable until `done`, then advances the duck position by its velocity, bouncing off the play-field edges. Shot hits switch the duck to falling; surviving a fixed number of steps switches it to escaping. Outputs feed the sprite/display stage and the game-round logic.

## Interface
- `X_W`, 10, x coordinate width (unsigned)
- `Y_W`, 10, y coordinate width (unsigned)
- `DLY_W`, 10, delay width; equals the attached counter's `N`
- `X_MAX`, 639, rightmost legal x
- `Y_FLOOR`, 399, lowest legal y (grass line)
- `ESC_STEPS`, 64, steps flown before escape begins
- `ESC_SPEED`, 4, upward pixels per step while escaping

- `clk` in 1 clock
- `reset` in 1 synchronous, active-high
- `start` in 1 launch request, sampled in IDLE only
- `start_x` in X_W initial x
- `start_y` in Y_W initial y
- `vx`, `vy` in 4 each, signed two's-complement velocity, pixels/step, latched on start
- `step_delay` in DLY_W counter load value, latched on start
- `hit` in 1 shot registered on this duck
- `timer_ld` out 1 counter load strobe
- `timer_en` out 1 counter enable
- `timer_data` out DLY_W counter load value
- `timer_done` in 1 counter expiry
- `duck_x` out X_W, `duck_y` out Y_W current position
- `dir_left` out 1 current vx < 0 (sprite flip)
- `active` out 1 duck on screen
- `falling` out 1 duck hit
- `escaped` out 1 pulse, duck left the top
- `round_done` out 1 pulse, duck finished (fell or escaped)

## Operation
- States: IDLE, LOAD, WAIT, STEP. A mode register holds FLY, ESC or FALL.
- IDLE: on `start`, latch position, velocity and delay; set mode FLY and step count 0; go to LOAD.
- LOAD: `timer_ld`=1 for exactly one cycle, `timer_data`=latched delay; go to WAIT.
- WAIT: `timer_en`=1 until `timer_done`=1, then go to STEP with `timer_en`=0.
- STEP: apply mode update for one cycle, then return to LOAD, or to IDLE if finished.
- FLY update:
  - x' = x+vx and y' = y+vy, computed signed at width+1.
  - x'<0 gives x=0 and vx negated. x'>X_MAX gives x=X_MAX and vx negated. y is handled the same way against 0 and Y_FLOOR.
  - Step count increments. When it reaches ESC_STEPS, mode becomes ESC.
- ESC update: y -= ESC_SPEED, x unchanged. If y<=ESC_SPEED, y=0 and the duck finishes as escaped.
- `hit` in LOAD/WAIT/STEP while mode is FLY or ESC sets mode FALL and `falling`=1. Hit in IDLE or FALL is ignored.
- `hit` and `timer_done` in the same cycle: hit wins, and the current step is applied using FALL rules.
- `start` while not in IDLE is ignored.
- `dir_left` tracks the sign of the live vx.
- Finish: `round_done`=1 for one cycle, `escaped` pulses with it on escape. `active` and `falling` clear and the block returns to IDLE. Position holds its last value.

## Timing
- Reset values: `timer_ld`, `timer_en` and `timer_data` 0; `duck_x` and `duck_y` 0; `dir_left`, `active`, `falling`, `escaped` and `round_done` 0; state IDLE.
- Reset mid-flight aborts immediately with no `round_done`.
- All outputs are registered.
- `start` at cycle t: `active`=1 and `timer_ld`=1 at t+1, `timer_en`=1 from t+2.
- `timer_done` seen at cycle u: the new position is visible at u+2, and the next `timer_ld` is at u+2.
- `timer_en` is low during STEP and LOAD, so the counter clears `done` before the next wait.
- `timer_ld` and `timer_en` are never high together.

## Configuration
- `DUCK_FALL_ANIM_EN` defined: FALL steps do y += 8 with x unchanged. When y reaches Y_FLOOR (clamped), the duck finishes and `round_done` pulses.
- `DUCK_FALL_ANIM_EN` undefined: on a hit the block finishes at the next STEP with no motion (`round_done` pulse), and the timer is still loaded and waited once.
- FSM and interface are identical in both builds.

## Test plan
- Bench models `down_counter`; `step_delay`=2.
- Launch from start_x=100, start_y=200 with vx=+3, vy=-2 -> after 3 steps the position is (109,194), `dir_left`=0, and the `timer_ld` pulses are evenly spaced.
- Start at start_x=638 with vx=+3 -> after step 1, x=639 and `dir_left`=1; after step 2, x=636.
- Let ESC_STEPS pass with start_y=20 -> ESC steps move y 20→16→…→4→0. One cycle of `escaped`=`round_done`=1, then `active`=0.
- Assert `hit` on the same cycle as `timer_done` at y=390 with the macro on -> `falling`=1, and the next y is 398 then 399, followed by `round_done`. With the macro off, `round_done` follows a single step.
- Assert `reset` during WAIT -> all outputs are 0 the next cycle and there is no `round_done`. A fresh `start` then relaunches normally.
- `start` pulse while active and `hit` while IDLE -> both ignored, with no state change.
